// File: rtl/baud_autotrain.sv
// Purpose: trains baudclock from the raw rx line, drives its config, and supervises lock.
// Latency: all outputs registered; a state change shows one clk after its causing input.
// Backpressure: none; rx and baudclock flags are sampled every cycle and never stalled.
module baud_autotrain #(
  parameter int COUNTER_WIDTH    = 24,
  parameter int EDGES_TO_MEASURE = 16,
  parameter int MIN_PERIOD       = 8,
  parameter int WINDOW_SHIFT     = 3,
  parameter int LOSS_LIMIT       = 4,
  parameter int LOCK_HOLD        = 8,
  parameter int RETRAIN_MAX      = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic                     rx,
  input  logic                     bc_baud,
  input  logic                     bc_lock,
  input  logic                     bc_glitch,
  output logic                     bc_rst,
  output logic [COUNTER_WIDTH-1:0] count_max,
  output logic [COUNTER_WIDTH-1:0] count_mid,
  output logic [COUNTER_WIDTH-1:0] sync_max,
  output logic [COUNTER_WIDTH-1:0] sync_min,
  output logic                     config_valid,
  output logic                     busy,
  output logic                     fault,
  output logic [7:0]               glitch_cnt
);

  typedef enum logic [2:0] {IDLE, MEASURE, CONFIG, SETTLE, RUN, FAULT} state_e;

  localparam int EW = $clog2(EDGES_TO_MEASURE + 1);
  localparam int LW = $clog2(LOSS_LIMIT + 1);
  localparam int HW = $clog2(LOCK_HOLD + 1);
  localparam int RW = (RETRAIN_MAX > 0) ? $clog2(RETRAIN_MAX + 1) : 1;
  localparam logic [COUNTER_WIDTH-1:0] CNT_ONES = '1;

  state_e                   state_q;
  logic                     rx_prev_q, lock_prev_q, baud_prev_q, glitch_prev_q;
  logic [COUNTER_WIDTH-1:0] ivl_q, min_period_q;
  logic                     first_seen_q;
  logic [EW-1:0]            edges_seen_q;
  logic [1:0]               settle_q;
  logic [LW-1:0]            loss_cnt_q, loss_cnt_d;
  logic [HW-1:0]            hold_cnt_q, hold_cnt_d;
  logic [RW-1:0]            retrain_cnt_q;
  logic [COUNTER_WIDTH-1:0] count_max_q, count_mid_q, sync_max_q, sync_min_q;
  logic                     bc_rst_q, config_valid_q, busy_q, fault_q;
  logic [7:0]               glitch_cnt_q;

  logic                     rx_edge, lock_fall, baud_rise, glitch_rise, sample_ok;
  logic [COUNTER_WIDTH-1:0] ivl_len, win, cmax_new;

  // Edge events, candidate interval, config arithmetic and RUN-state lock bookkeeping
  always_comb begin
    rx_edge     = rx ^ rx_prev_q;
    lock_fall   = lock_prev_q & ~bc_lock;
    baud_rise   = bc_baud & ~baud_prev_q;
    glitch_rise = bc_glitch & ~glitch_prev_q;
    // ivl_len only matters when ivl_q is below saturation, so it cannot wrap
    ivl_len     = ivl_q + COUNTER_WIDTH'(1);
    sample_ok   = rx_edge && (ivl_len >= COUNTER_WIDTH'(MIN_PERIOD));
    cmax_new    = min_period_q - COUNTER_WIDTH'(1);
    win         = min_period_q >> WINDOW_SHIFT;
    if (win == '0) win = COUNTER_WIDTH'(1);
    // a lock drop outranks a baud tick arriving in the same cycle
    loss_cnt_d  = loss_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    if (lock_fall) begin
      loss_cnt_d = loss_cnt_q + LW'(1);
      hold_cnt_d = '0;
    end else if (baud_rise && bc_lock) begin
      if (hold_cnt_q == HW'(LOCK_HOLD - 1)) begin
        loss_cnt_d = '0;
        hold_cnt_d = '0;
      end else begin
        hold_cnt_d = hold_cnt_q + HW'(1);
      end
    end
  end

  // Training and supervision state machine with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      rx_prev_q      <= 1'b1;
      lock_prev_q    <= 1'b0;
      baud_prev_q    <= 1'b0;
      glitch_prev_q  <= 1'b0;
      ivl_q          <= '0;
      min_period_q   <= CNT_ONES;
      first_seen_q   <= 1'b0;
      edges_seen_q   <= '0;
      settle_q       <= '0;
      loss_cnt_q     <= '0;
      hold_cnt_q     <= '0;
      retrain_cnt_q  <= '0;
      count_max_q    <= '0;
      count_mid_q    <= '0;
      sync_max_q     <= '0;
      sync_min_q     <= '0;
      bc_rst_q       <= 1'b1;
      config_valid_q <= 1'b0;
      busy_q         <= 1'b0;
      fault_q        <= 1'b0;
      glitch_cnt_q   <= '0;
    end else begin
      rx_prev_q     <= rx;
      lock_prev_q   <= bc_lock;
      baud_prev_q   <= bc_baud;
      glitch_prev_q <= bc_glitch;
      if (!enable) begin
        state_q  <= IDLE;
        bc_rst_q <= 1'b1;
        busy_q   <= 1'b0;
        fault_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            state_q       <= MEASURE;
            busy_q        <= 1'b1;
            bc_rst_q      <= 1'b1;
            retrain_cnt_q <= '0;
            loss_cnt_q    <= '0;
            hold_cnt_q    <= '0;
            first_seen_q  <= 1'b0;
            edges_seen_q  <= '0;
            min_period_q  <= CNT_ONES;
            ivl_q         <= '0;
          end
          MEASURE: begin
            if (!first_seen_q) begin
              if (rx_edge) begin
                first_seen_q <= 1'b1;
                ivl_q        <= '0;
              end
            end else if (ivl_q == CNT_ONES) begin
              // line went quiet for a full counter range: start the pass over
              first_seen_q <= 1'b0;
              edges_seen_q <= '0;
              min_period_q <= CNT_ONES;
              ivl_q        <= '0;
            end else if (sample_ok) begin
              if (ivl_len < min_period_q) min_period_q <= ivl_len;
              edges_seen_q <= edges_seen_q + EW'(1);
              ivl_q        <= '0;
              if (edges_seen_q == EW'(EDGES_TO_MEASURE - 1)) state_q <= CONFIG;
            end else begin
              // too-short edges are glitches; the running interval keeps counting
              ivl_q <= ivl_len;
            end
          end
          CONFIG: begin
            count_max_q    <= cmax_new;
            count_mid_q    <= cmax_new >> 1;
            sync_max_q     <= win;
            sync_min_q     <= cmax_new - win;
            config_valid_q <= 1'b1;
            settle_q       <= '0;
            state_q        <= SETTLE;
          end
          SETTLE: begin
            if (settle_q == 2'd1) begin
              state_q  <= RUN;
              bc_rst_q <= 1'b0;
              busy_q   <= 1'b0;
            end else begin
              settle_q <= settle_q + 2'd1;
            end
          end
          RUN: begin
            if (glitch_rise && (glitch_cnt_q != 8'hFF)) glitch_cnt_q <= glitch_cnt_q + 8'd1;
            if (loss_cnt_d == LW'(LOSS_LIMIT)) begin
              loss_cnt_q     <= '0;
              hold_cnt_q     <= '0;
              config_valid_q <= 1'b0;
              bc_rst_q       <= 1'b1;
              if (retrain_cnt_q == RW'(RETRAIN_MAX)) begin
                state_q <= FAULT;
                fault_q <= 1'b1;
              end else begin
                // old config stays on the outputs while the new pass runs
                retrain_cnt_q <= retrain_cnt_q + RW'(1);
                state_q       <= MEASURE;
                busy_q        <= 1'b1;
                first_seen_q  <= 1'b0;
                edges_seen_q  <= '0;
                min_period_q  <= CNT_ONES;
                ivl_q         <= '0;
              end
            end else begin
              loss_cnt_q <= loss_cnt_d;
              hold_cnt_q <= hold_cnt_d;
            end
          end
          FAULT:   state_q <= FAULT;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bc_rst       = bc_rst_q;
  assign count_max    = count_max_q;
  assign count_mid    = count_mid_q;
  assign sync_max     = sync_max_q;
  assign sync_min     = sync_min_q;
  assign config_valid = config_valid_q;
  assign busy         = busy_q;
  assign fault        = fault_q;
  assign glitch_cnt   = glitch_cnt_q;

endmodule

// File: tb/tb_baud_autotrain.sv
// Purpose: self-checking bench for baud_autotrain with a timestamp-based reference model.
// Latency: model predicts post-edge outputs; compared on every falling clk edge.
// Backpressure: none; stimulus drives rx and baudclock flags freely.
`timescale 1ns/1ps
module tb_baud_autotrain;

  localparam int     CW   = 24;
  localparam longint MAXC = longint'(1) << CW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0, rx = 1'b1, bc_baud = 1'b0, bc_lock = 1'b1, bc_glitch = 1'b0;
  logic          bc_rst, config_valid, busy, fault;
  logic [CW-1:0] count_max, count_mid, sync_max, sync_min;
  logic [7:0]    glitch_cnt;

  logic          en8 = 1'b0, rx8 = 1'b1;
  logic          bc_rst8, cv8, busy8, fault8;
  logic [7:0]    cm8, cmid8, smax8, smin8, gc8;

  always #5 clk = ~clk;

  baud_autotrain #(.COUNTER_WIDTH(CW)) u_dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .rx(rx),
    .bc_baud(bc_baud), .bc_lock(bc_lock), .bc_glitch(bc_glitch),
    .bc_rst(bc_rst), .count_max(count_max), .count_mid(count_mid),
    .sync_max(sync_max), .sync_min(sync_min), .config_valid(config_valid),
    .busy(busy), .fault(fault), .glitch_cnt(glitch_cnt)
  );

  baud_autotrain #(.COUNTER_WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .enable(en8), .rx(rx8),
    .bc_baud(1'b0), .bc_lock(1'b1), .bc_glitch(1'b0),
    .bc_rst(bc_rst8), .count_max(cm8), .count_mid(cmid8),
    .sync_max(smax8), .sync_min(smin8), .config_valid(cv8),
    .busy(busy8), .fault(fault8), .glitch_cnt(gc8)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  localparam int M_IDLE = 0, M_MEAS = 1, M_CONF = 2, M_SETL = 3, M_RUN = 4, M_FLT = 5;
  int     md = M_IDLE;
  longint cyc = 0, last_edge = 0, minp = MAXC - 1, d = 0, w = 0;
  bit     have_first = 0;
  int     samples = 0, settle_left = 0, loss = 0, hold = 0, retrains = 0;
  bit     p_rx = 1, p_lock = 0, p_baud = 0, p_glitch = 0;
  bit     ev_edge, ev_lf, ev_br, ev_gr;
  longint e_cmax = 0, e_cmid = 0, e_smax = 0, e_smin = 0;
  bit     e_cv = 0, e_busy = 0, e_fault = 0, e_bcrst = 1;
  int     e_gcnt = 0;

  task automatic new_pass();
    have_first = 0;
    samples    = 0;
    minp       = MAXC - 1;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      md = M_IDLE; cyc = 0; new_pass(); loss = 0; hold = 0; retrains = 0;
      p_rx = 1; p_lock = 0; p_baud = 0; p_glitch = 0;
      e_cmax = 0; e_cmid = 0; e_smax = 0; e_smin = 0;
      e_cv = 0; e_busy = 0; e_fault = 0; e_bcrst = 1; e_gcnt = 0;
    end else begin
      cyc++;
      ev_edge  = (rx != p_rx);
      ev_lf    = p_lock && !bc_lock;
      ev_br    = bc_baud && !p_baud;
      ev_gr    = bc_glitch && !p_glitch;
      p_rx = rx; p_lock = bc_lock; p_baud = bc_baud; p_glitch = bc_glitch;
      if (!enable) begin
        md = M_IDLE; e_bcrst = 1; e_busy = 0; e_fault = 0;
      end else begin
        case (md)
          M_IDLE: begin
            md = M_MEAS; e_busy = 1; retrains = 0; loss = 0; hold = 0; new_pass();
          end
          M_MEAS: begin
            if (!have_first) begin
              if (ev_edge) begin have_first = 1; last_edge = cyc; end
            end else begin
              d = cyc - last_edge;   // interval length in clocks
              if (d >= MAXC) new_pass();
              else if (ev_edge && d >= 8) begin
                if (d < minp) minp = d;
                samples++;
                last_edge = cyc;
                if (samples == 16) md = M_CONF;
              end
            end
          end
          M_CONF: begin
            w = minp / 8;
            if (w < 1) w = 1;
            e_cmax = minp - 1; e_cmid = (minp - 1) / 2; e_smax = w; e_smin = minp - 1 - w;
            e_cv = 1; md = M_SETL; settle_left = 2;
          end
          M_SETL: begin
            settle_left--;
            if (settle_left == 0) begin md = M_RUN; e_bcrst = 0; e_busy = 0; end
          end
          M_RUN: begin
            if (ev_gr && e_gcnt < 255) e_gcnt++;
            if (ev_lf) begin loss++; hold = 0; end
            else if (ev_br && bc_lock) begin
              hold++;
              if (hold == 8) begin loss = 0; hold = 0; end
            end
            if (loss == 4) begin
              loss = 0; hold = 0; e_cv = 0; e_bcrst = 1;
              if (retrains == 3) begin md = M_FLT; e_fault = 1; end
              else begin retrains++; md = M_MEAS; e_busy = 1; new_pass(); end
            end
          end
          default: ;
        endcase
      end
    end
  end

  // single compare process against the model
  always @(negedge clk) begin
    chk("bc_rst", bc_rst, e_bcrst);
    chk("count_max", count_max, e_cmax);
    chk("count_mid", count_mid, e_cmid);
    chk("sync_max", sync_max, e_smax);
    chk("sync_min", sync_min, e_smin);
    chk("config_valid", config_valid, e_cv);
    chk("busy", busy, e_busy);
    chk("fault", fault, e_fault);
    chk("glitch_cnt", glitch_cnt, e_gcnt);
  end

  // ---------------- stimulus ----------------
  int n;
  int pat[4] = '{300, 100, 200, 100};
  int p_last;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_cyc(input int k);
    repeat (k) tick();
  endtask

  task automatic lock_drop();
    bc_lock = 1'b0; tick(); bc_lock = 1'b1; tick();
  endtask

  task automatic baud_rise();
    bc_baud = 1'b1; tick(); bc_baud = 1'b0; tick();
  endtask

  task automatic wait_cv(input string tag);
    int k;
    k = 0;
    while (!config_valid && k < 200) begin tick(); k++; end
    chk({tag, "_config_valid"}, config_valid, 1);
  endtask

  task automatic wait_run(input string tag);
    int k;
    k = 0;
    while (bc_rst && k < 10) begin tick(); k++; end
    chk({tag, "_bc_rst_low"}, bc_rst, 0);
  endtask

  task automatic force_loss(input string tag);
    for (int i = 0; i < 40; i++) begin
      lock_drop();
      if (bc_rst) break;
      repeat ($urandom_range(0, 7)) baud_rise();
    end
    chk({tag, "_bc_rst_high"}, bc_rst, 1);
  endtask

  task automatic train_random(output int p);
    int exact_i, iv, g;
    p = $urandom_range(20, 150);
    exact_i = $urandom_range(0, 15);
    tick(); tick();
    rx = ~rx;
    for (int i = 0; i < 16; i++) begin
      iv = (i == exact_i) ? p : p + $urandom_range(0, p);
      if ($urandom_range(0, 3) == 0) begin
        g = $urandom_range(1, 4);
        wait_cyc(g); rx = ~rx; wait_cyc(3); rx = ~rx; wait_cyc(iv - g - 3);
      end else begin
        wait_cyc(iv);
      end
      rx = ~rx;
    end
    wait_cv("rand");
    chk("rand_count_max", count_max, p - 1);
    chk("rand_sync_max", sync_max, p / 8);
    wait_run("rand");
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_bc_rst", bc_rst, 1);
    chk("rst_count_max", count_max, 0);
    chk("rst_config_valid", config_valid, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    tick(); tick();

    // 100 clocks per bit, 17 edges
    enable = 1'b1;
    tick(); tick();
    chk("meas_busy", busy, 1);
    rx = ~rx;
    repeat (16) begin wait_cyc(100); rx = ~rx; end
    wait_cv("s1");
    chk("s1_count_max", count_max, 99);
    chk("s1_count_mid", count_mid, 49);
    chk("s1_sync_max", sync_max, 12);
    chk("s1_sync_min", sync_min, 87);
    n = 0;
    while (bc_rst && n < 10) begin tick(); n++; end
    chk("s1_bc_rst_fall_delay", n, 2);

    // lock hold clears accumulated losses
    repeat (3) lock_drop();
    repeat (8) baud_rise();
    repeat (3) lock_drop();
    tick();
    chk("hold_still_run", bc_rst, 0);
    chk("hold_cv", config_valid, 1);
    bc_lock = 1'b0; tick();
    chk("retrain_bc_rst", bc_rst, 1);
    chk("retrain_cv", config_valid, 0);
    chk("retrain_busy", busy, 1);
    chk("retrain_cfg_held", count_max, 99);
    bc_lock = 1'b1; tick(); tick();

    // mixed run lengths with a short glitch pair
    rx = ~rx;
    for (int i = 0; i < 16; i++) begin
      if (i == 5) begin
        wait_cyc(2); rx = ~rx; wait_cyc(3); rx = ~rx; wait_cyc(pat[i % 4] - 5);
      end else begin
        wait_cyc(pat[i % 4]);
      end
      rx = ~rx;
    end
    wait_cv("mix");
    chk("mix_count_max", count_max, 99);
    chk("mix_count_mid", count_mid, 49);
    chk("mix_sync_max", sync_max, 12);
    chk("mix_sync_min", sync_min, 87);
    wait_run("mix");

    // random baud/glitch activity in RUN, then glitch counter saturation
    for (int i = 0; i < 150; i++) begin
      bc_baud = 1'($urandom_range(0, 1));
      bc_glitch = 1'($urandom_range(0, 1));
      tick();
    end
    bc_baud = 1'b0; bc_glitch = 1'b0; tick();
    repeat (260) begin bc_glitch = 1'b1; tick(); bc_glitch = 1'b0; tick(); end
    chk("glitch_sat", glitch_cnt, 255);

    // retrains 2 and 3, then fault
    force_loss("loss2");
    train_random(p_last);
    force_loss("loss3");
    train_random(p_last);
    force_loss("loss4");
    chk("fault_set", fault, 1);
    chk("fault_cv", config_valid, 0);
    wait_cyc(5);
    chk("fault_sticky", fault, 1);
    enable = 1'b0; tick();
    chk("idle_fault_clr", fault, 0);
    chk("idle_busy", busy, 0);
    chk("idle_bc_rst", bc_rst, 1);
    chk("idle_cfg_held", count_max, p_last - 1);

    // reset in the middle of a measurement pass
    enable = 1'b1; tick(); tick();
    rx = ~rx;
    repeat (5) begin wait_cyc(50); rx = ~rx; end
    @(posedge clk); #3;
    rst_n = 1'b0; enable = 1'b0;
    #1;
    chk("mid_rst_bc_rst", bc_rst, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_cv", config_valid, 0);
    chk("mid_rst_count_max", count_max, 0);
    chk("mid_rst_sync_min", sync_min, 0);
    chk("mid_rst_glitch_cnt", glitch_cnt, 0);
    tick(); tick();
    rst_n = 1'b1; tick();

    // 8-bit counter: a silent line restarts the pass
    en8 = 1'b1; tick(); tick();
    rx8 = ~rx8;
    repeat (10) begin wait_cyc(20); rx8 = ~rx8; end
    wait_cyc(300);
    chk("to_busy", busy8, 1);
    chk("to_bc_rst", bc_rst8, 1);
    chk("to_cv", cv8, 0);
    rx8 = ~rx8;
    repeat (16) begin wait_cyc(30); rx8 = ~rx8; end
    n = 0;
    while (!cv8 && n < 20) begin tick(); n++; end
    chk("to_cv_after", cv8, 1);
    chk("to_count_max", cm8, 29);
    chk("to_count_mid", cmid8, 14);
    chk("to_sync_max", smax8, 3);
    chk("to_sync_min", smin8, 26);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #900000;
    n_err++;
    $display("FAIL watchdog: simulation did not complete, expected completion before %0t", $time);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/baud_autotrain.md
Name: baud_autotrain

Overview:
- Controller that sequences the team's baud clock recovery block (baudclock) for the CAN/UART receive path.
- Measures the shortest rx edge-to-edge interval to estimate the bit period, then computes and drives count_max, count_mid, sync_max and sync_min.
- Holds baudclock in reset until the configuration is valid, and monitors its lock and glitch flags.
- Retrains on repeated loss of lock and declares a sticky fault if retraining keeps failing.

Parameters:
- COUNTER_WIDTH, 24, width of all period and count values; matches baudclock.
- EDGES_TO_MEASURE, 16, number of valid intervals collected per training pass.
- MIN_PERIOD, 8, intervals shorter than this many clk cycles are rejected as glitches.
- WINDOW_SHIFT, 3, sync window half-width = period >> WINDOW_SHIFT.
- LOSS_LIMIT, 4, lock-loss events in RUN that trigger a retrain.
- LOCK_HOLD, 8, consecutive bc_baud rising edges with lock high that clear the loss count.
- RETRAIN_MAX, 3, retrains allowed before FAULT.

Ports:
- clk  in  1  system clock, shared with baudclock.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  high = train and run; low = idle.
- rx  in  1  raw rx line, the same net that feeds baudclock.
- bc_baud  in  1  baudclock baud output.
- bc_lock  in  1  baudclock lock output.
- bc_glitch  in  1  baudclock glitch output.
- bc_rst  out  1  drives baudclock rst; active high.
- count_max  out  COUNTER_WIDTH  to baudclock.
- count_mid  out  COUNTER_WIDTH  to baudclock.
- sync_max  out  COUNTER_WIDTH  to baudclock.
- sync_min  out  COUNTER_WIDTH  to baudclock.
- config_valid  out  1  configuration outputs hold a trained value.
- busy  out  1  state is MEASURE, CONFIG or SETTLE.
- fault  out  1  sticky training failure.
- glitch_cnt  out  8  saturating count of bc_glitch rising edges in RUN.

Behaviour:
- Reset (rst_n low, async):
  - state = IDLE, bc_rst = 1.
  - count_max, count_mid, sync_max and sync_min = 0.
  - config_valid, busy and fault = 0.
  - glitch_cnt = 0 and all internal counters = 0.
  - min_period = all ones; rx_prev = 1.
- Edge detection:
  - edge = rx XOR rx_prev; rx_prev is registered every cycle.
  - bc_lock, bc_glitch and bc_baud are registered once each for edge detection.
- IDLE:
  - bc_rst = 1.
  - enable high: go to MEASURE, clear edges_seen and retrain_cnt, set min_period = all ones.
- MEASURE (bc_rst = 1, busy = 1):
  - ivl increments every cycle and saturates at all ones.
  - First edge: ivl = 0, no sample taken.
  - Later edges with ivl+1 >= MIN_PERIOD: min_period = min(min_period, ivl+1), edges_seen++, ivl = 0.
  - Edges with ivl+1 < MIN_PERIOD are ignored entirely; ivl is not restarted.
  - ivl saturates: restart the pass (edges_seen = 0, min_period = all ones, wait for a first edge again).
  - edges_seen == EDGES_TO_MEASURE: go to CONFIG.
- CONFIG (1 cycle), with P = min_period:
  - count_max = P-1.
  - count_mid = (P-1) >> 1.
  - w = max(P >> WINDOW_SHIFT, 1).
  - sync_max = w; sync_min = count_max - w.
  - config_valid = 1, then go to SETTLE.
  - All arithmetic is unsigned COUNTER_WIDTH; no wrap is possible because P >= MIN_PERIOD > w.
- SETTLE (busy = 1):
  - bc_rst is held 1 for 2 cycles so baudclock sees stable config, then go to RUN.
- RUN (bc_rst = 0):
  - Falling edge of bc_lock: loss_cnt++ and hold_cnt = 0.
  - Rising edge of bc_baud while bc_lock = 1: hold_cnt++; hold_cnt reaching LOCK_HOLD sets loss_cnt = 0 and hold_cnt = 0.
  - Lock fall and baud rise in the same cycle: loss_cnt increments and hold_cnt clears (loss wins).
  - Rising edge of bc_glitch: glitch_cnt++, saturating at 255.
  - loss_cnt == LOSS_LIMIT:
    - If retrain_cnt == RETRAIN_MAX: go to FAULT.
    - Otherwise retrain_cnt++ and go to MEASURE: bc_rst = 1 next cycle, config_valid = 0, old config values are held, loss_cnt = 0.
- FAULT:
  - bc_rst = 1, fault = 1, config_valid = 0.
  - Stays in FAULT until enable goes low.
- enable low in any state:
  - Next cycle: state = IDLE, bc_rst = 1, busy = 0, fault = 0.
  - config values and config_valid are held; glitch_cnt is held.
- Output timing: all outputs are registered; a state change is visible on outputs one cycle after the causing input.
- Reset mid-training: immediate return to the reset values above; no partial config is ever marked valid.

Test Plan:
- Train at 100 cycles/bit: toggle rx every 100 cycles, 17 edges, enable = 1 -> CONFIG gives count_max = 99, count_mid = 49, sync_max = 12, sync_min = 87; config_valid = 1; bc_rst falls 2 cycles after CONFIG.
- Mixed run lengths: intervals 300, 100, 200, 100, ... (16 valid) plus one 3-cycle glitch pair -> min_period = 100, glitch ignored, same config as the first scenario.
- Timeout: COUNTER_WIDTH = 8, a single rx edge then silence -> pass restarts after ivl saturates at 255, edges_seen = 0, state stays MEASURE.
- Retrain: in RUN, pulse bc_lock low 4 times with fewer than 8 bc_baud rises between them -> MEASURE, bc_rst = 1, config_valid = 0, retrain_cnt = 1.
- Hold clears loss: 3 lock drops, then 8 bc_baud rises with lock = 1, then 3 more drops -> stays in RUN.
- Fault and recovery: force 4 retrains -> fault = 1 and bc_rst = 1; enable low for 1 cycle -> IDLE and fault = 0; assert rst_n low mid-MEASURE -> all outputs return to their reset values immediately.
